// File: rtl/sdbank_pkg.sv
// Shared definitions for the frame-buffer bank ring switch: FSM encoding and
// the bank-allocation helper used by the writer.
package sdbank_pkg;

  typedef enum logic [2:0] {
    ST_LOAD0 = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLR   = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } fb_state_t;

  // Lowest bank that is neither excl_a (reader) nor excl_b (newest frame).
  // With two banks only the reader's bank is excluded (ping-pong).
  function automatic int next_free_bank(input int excl_a, input int excl_b,
                                        input int num_banks);
    int pick;
    pick = (excl_a == 0) ? 1 : 0;
    if (num_banks > 2) begin
      for (int i = 3; i >= 0; i--) begin
        if (i < num_banks && i != excl_a && i != excl_b) pick = i;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sdbank_sync_edge.sv
// Two-flop falling-edge detector for a frame-valid input; flag is high for
// exactly one cycle, two cycles after the input falls.
module sdbank_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sync,
  output logic flag
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= sync;
      sync_p1 <= sync_p0;
    end
  end

  assign flag = sync_p1 & ~sync_p0;

endmodule

// File: rtl/sdbank_ring_switch.sv
// N-bank ring frame-buffer arbiter: writer and reader advance independently on
// their own frame boundaries; reader always takes the newest completed frame.
module sdbank_ring_switch
  import sdbank_pkg::*;
#(
  parameter int NUM_BANKS = 3,
  parameter int BANK_W    = 2,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_frame_sync,
  input  logic              rd_frame_sync,
  input  logic              frame_write_done,
  input  logic              frame_read_done,
  input  logic              freeze,
  output logic [BANK_W-1:0] wr_bank,
  output logic [BANK_W-1:0] rd_bank,
  output logic              wr_load,
  output logic              rd_load,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  repeat_cnt
);

  fb_state_t         wr_state, wr_state_nxt;
  fb_state_t         rd_state, rd_state_nxt;
  logic              wr_flag, rd_flag;
  logic              wr_commit, rd_select, rd_take;
  logic [BANK_W-1:0] latest;
  logic              latest_valid;
  logic [BANK_W-1:0] rd_bank_next;
  logic [BANK_W-1:0] wr_bank_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  sdbank_sync_edge u_wr_edge (
    .clk  (clk),
    .rst  (rst),
    .sync (wr_frame_sync),
    .flag (wr_flag)
  );

  sdbank_sync_edge u_rd_edge (
    .clk  (clk),
    .rst  (rst),
    .sync (rd_frame_sync),
    .flag (rd_flag)
  );

  always_ff @(posedge clk) begin
    if (rst) wr_state <= ST_LOAD0;
    else     wr_state <= wr_state_nxt;
  end

  always_comb begin
    wr_state_nxt = wr_state;
    wr_load      = 1'b0;
    wr_commit    = 1'b0;
    case (wr_state)
      ST_LOAD0: wr_state_nxt = ST_LOAD;
      ST_LOAD: begin
        wr_load      = 1'b1;
        wr_state_nxt = ST_CLR;
      end
      ST_CLR:   wr_state_nxt = ST_RUN;
      ST_RUN:   if (wr_flag) wr_state_nxt = ST_DONE;
      ST_DONE: begin
        if (frame_write_done) begin
          wr_commit    = 1'b1;
          wr_state_nxt = ST_LOAD0;
        end
      end
      default:  wr_state_nxt = ST_LOAD0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) rd_state <= ST_LOAD0;
    else     rd_state <= rd_state_nxt;
  end

  always_comb begin
    rd_state_nxt = rd_state;
    rd_load      = 1'b0;
    rd_select    = 1'b0;
    case (rd_state)
      ST_LOAD0: rd_state_nxt = ST_LOAD;
      ST_LOAD: begin
        rd_load      = 1'b1;
        rd_state_nxt = ST_CLR;
      end
      ST_CLR:   rd_state_nxt = ST_RUN;
      ST_RUN:   if (rd_flag) rd_state_nxt = ST_DONE;
      ST_DONE: begin
        if (frame_read_done) begin
          rd_select    = 1'b1;
          rd_state_nxt = ST_LOAD0;
        end
      end
      default:  rd_state_nxt = ST_LOAD0;
    endcase
  end

  // Reader sees the pre-commit latest; writer excludes the post-select reader bank.
  assign rd_take      = rd_select && !freeze && latest_valid && (latest != rd_bank);
  assign rd_bank_next = rd_take ? latest : rd_bank;
  assign wr_bank_next = BANK_W'(next_free_bank(int'(rd_bank_next), int'(wr_bank), NUM_BANKS));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank      <= '0;
      rd_bank      <= BANK_W'(NUM_BANKS - 1);
      latest       <= '0;
      latest_valid <= 1'b0;
      drop_cnt     <= '0;
      repeat_cnt   <= '0;
    end else begin
      rd_bank <= rd_bank_next;
      if (rd_select && !rd_take) repeat_cnt <= sat_inc(repeat_cnt);
      if (wr_commit) begin
        if (latest_valid && (latest != rd_bank_next)) drop_cnt <= sat_inc(drop_cnt);
        latest       <= wr_bank;
        latest_valid <= 1'b1;
        wr_bank      <= wr_bank_next;
      end
    end
  end

endmodule

// File: tb/tb_sdbank_ring_switch.sv
// Directed bench for the bank ring switch: a triple-buffer instance and a
// two-bank instance with narrow counters for ping-pong and saturation.
module tb_sdbank_ring_switch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       wr_frame_sync, rd_frame_sync, frame_write_done, frame_read_done, freeze;
  logic [1:0] wr_bank, rd_bank;
  logic       wr_load, rd_load;
  logic [7:0] drop_cnt, repeat_cnt;

  logic       pp_wr_sync, pp_rd_sync, pp_wr_done, pp_rd_done, pp_freeze;
  logic       pp_wr_bank, pp_rd_bank, pp_wr_load, pp_rd_load;
  logic [1:0] pp_drop, pp_rep;

  int total = 0;
  int bad   = 0;

  sdbank_ring_switch #(.NUM_BANKS(3), .BANK_W(2), .CNT_W(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .wr_frame_sync    (wr_frame_sync),
    .rd_frame_sync    (rd_frame_sync),
    .frame_write_done (frame_write_done),
    .frame_read_done  (frame_read_done),
    .freeze           (freeze),
    .wr_bank          (wr_bank),
    .rd_bank          (rd_bank),
    .wr_load          (wr_load),
    .rd_load          (rd_load),
    .drop_cnt         (drop_cnt),
    .repeat_cnt       (repeat_cnt)
  );

  sdbank_ring_switch #(.NUM_BANKS(2), .BANK_W(1), .CNT_W(2)) dut_pp (
    .clk              (clk),
    .rst              (rst),
    .wr_frame_sync    (pp_wr_sync),
    .rd_frame_sync    (pp_rd_sync),
    .frame_write_done (pp_wr_done),
    .frame_read_done  (pp_rd_done),
    .freeze           (pp_freeze),
    .wr_bank          (pp_wr_bank),
    .rd_bank          (pp_rd_bank),
    .wr_load          (pp_wr_load),
    .rd_load          (pp_rd_load),
    .drop_cnt         (pp_drop),
    .repeat_cnt       (pp_rep)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge; banks must never coincide.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst) begin
      total++;
      assert (wr_bank !== rd_bank) else begin
        bad++;
        $error("FAIL inv3: wr_bank=%0d rd_bank=%0d must differ", wr_bank, rd_bank);
      end
      total++;
      assert (pp_wr_bank !== pp_rd_bank) else begin
        bad++;
        $error("FAIL inv2: wr_bank=%0d rd_bank=%0d must differ", pp_wr_bank, pp_rd_bank);
      end
    end
  endtask

  // One frame: sync high for two cycles, then low; commit lands 3 edges after the fall.
  task automatic frame(input logic w, input logic r, input logic w2, input logic r2);
    wr_frame_sync = w;
    rd_frame_sync = r;
    pp_wr_sync    = w2;
    pp_rd_sync    = r2;
    tick();
    tick();
    wr_frame_sync = 1'b0;
    rd_frame_sync = 1'b0;
    pp_wr_sync    = 1'b0;
    pp_rd_sync    = 1'b0;
    repeat (4) tick();
  endtask

  task automatic step(input string tag, input logic w, input logic r,
                      input int ewr, input int erd);
    frame(w, r, 1'b0, 1'b0);
    chk({tag, "_wr"}, 32'(wr_bank), ewr);
    chk({tag, "_rd"}, 32'(rd_bank), erd);
  endtask

  task automatic pp_step(input string tag, input int ewr, input int erd, input int erep);
    frame(1'b0, 1'b0, 1'b1, 1'b1);
    chk({tag, "_wr"},  32'(pp_wr_bank), ewr);
    chk({tag, "_rd"},  32'(pp_rd_bank), erd);
    chk({tag, "_rep"}, 32'(pp_rep), erep);
  endtask

  initial begin
    rst = 1'b1;
    wr_frame_sync = 1'b0; rd_frame_sync = 1'b0;
    frame_write_done = 1'b1; frame_read_done = 1'b1; freeze = 1'b0;
    pp_wr_sync = 1'b0; pp_rd_sync = 1'b0;
    pp_wr_done = 1'b1; pp_rd_done = 1'b1; pp_freeze = 1'b0;

    // Reset state and load pulses after release
    repeat (3) tick();
    chk("rst_wr_bank", 32'(wr_bank), 0);
    chk("rst_rd_bank", 32'(rd_bank), 2);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_rep", 32'(repeat_cnt), 0);
    chk("rst_pp_rd_bank", 32'(pp_rd_bank), 1);
    rst = 1'b0;
    chk("c1_wr_load", 32'(wr_load), 0);
    chk("c1_rd_load", 32'(rd_load), 0);
    tick();
    chk("c2_wr_load", 32'(wr_load), 1);
    chk("c2_rd_load", 32'(rd_load), 1);
    tick();
    chk("c3_wr_load", 32'(wr_load), 0);
    chk("c3_rd_load", 32'(rd_load), 0);
    tick();
    tick();

    // Equal rates: reader follows each newly committed bank
    step("eq_w1", 1, 0, 1, 2);
    step("eq_r1", 0, 1, 1, 0);
    step("eq_w2", 1, 0, 2, 0);
    step("eq_r2", 0, 1, 2, 1);
    step("eq_w3", 1, 0, 0, 1);
    step("eq_r3", 0, 1, 0, 2);
    step("eq_w4", 1, 0, 1, 2);
    step("eq_r4", 0, 1, 1, 0);
    chk("eq_drop", 32'(drop_cnt), 0);
    chk("eq_rep", 32'(repeat_cnt), 0);

    // Writer twice as fast: every second write overwrites an unread frame
    step("fw_w1", 1, 0, 2, 0);
    step("fw_w2", 1, 0, 1, 0);
    step("fw_r1", 0, 1, 1, 2);
    step("fw_w3", 1, 0, 0, 2);
    step("fw_w4", 1, 0, 1, 2);
    step("fw_r2", 0, 1, 1, 0);
    step("fw_w5", 1, 0, 2, 0);
    step("fw_w6", 1, 0, 1, 0);
    step("fw_r3", 0, 1, 1, 2);
    chk("fw_drop", 32'(drop_cnt), 3);
    chk("fw_rep", 32'(repeat_cnt), 0);

    // Reader twice as fast: every other read repeats
    step("fr_w1", 1, 0, 0, 2);
    step("fr_r1", 0, 1, 0, 1);
    step("fr_r2", 0, 1, 0, 1);
    step("fr_w2", 1, 0, 2, 1);
    step("fr_r3", 0, 1, 2, 0);
    step("fr_r4", 0, 1, 2, 0);
    chk("fr_rep", 32'(repeat_cnt), 2);

    // Freeze holds the reader although a newer frame exists
    step("fz_w1", 1, 0, 1, 0);
    freeze = 1'b1;
    step("fz_r1", 0, 1, 1, 0);
    step("fz_r2", 0, 1, 1, 0);
    chk("fz_rep", 32'(repeat_cnt), 4);
    freeze = 1'b0;
    step("fz_r3", 0, 1, 1, 2);
    chk("fz_rep_after", 32'(repeat_cnt), 4);

    // Simultaneous commit and select from latest=1, wr=0, rd=2
    step("sim_pre", 1, 0, 0, 2);
    step("sim_both", 1, 1, 2, 1);
    chk("sim_drop", 32'(drop_cnt), 3);
    step("sim_latest", 0, 1, 2, 0);

    // Reset while both sides wait in DONE
    frame_write_done = 1'b0;
    frame_read_done  = 1'b0;
    wr_frame_sync = 1'b1; rd_frame_sync = 1'b1;
    tick(); tick();
    wr_frame_sync = 1'b0; rd_frame_sync = 1'b0;
    repeat (4) tick();
    chk("held_wr", 32'(wr_bank), 2);
    chk("held_rd", 32'(rd_bank), 0);
    rst = 1'b1;
    tick();
    chk("mid_rst_wr", 32'(wr_bank), 0);
    chk("mid_rst_rd", 32'(rd_bank), 2);
    chk("mid_rst_drop", 32'(drop_cnt), 0);
    chk("mid_rst_rep", 32'(repeat_cnt), 0);
    chk("mid_rst_wr_load", 32'(wr_load), 0);
    chk("mid_rst_rd_load", 32'(rd_load), 0);
    rst = 1'b0;
    frame_write_done = 1'b1;
    frame_read_done  = 1'b1;
    repeat (4) tick();

    // Commit one cycle after flag; a second fall during LOAD0 is ignored
    wr_frame_sync = 1'b1;
    tick(); tick();
    wr_frame_sync = 1'b0;
    tick();
    wr_frame_sync = 1'b1;
    tick();
    chk("pre_commit_wr", 32'(wr_bank), 0);
    wr_frame_sync = 1'b0;
    tick();
    chk("commit_wr", 32'(wr_bank), 1);
    repeat (6) tick();
    chk("ignored_wr", 32'(wr_bank), 1);
    chk("ignored_drop", 32'(drop_cnt), 0);
    step("post_rst_r", 0, 1, 1, 0);

    // Two-bank instance: lock-step frames, counter saturates at 3
    pp_step("pp1", 0, 1, 1);
    pp_step("pp2", 1, 0, 1);
    pp_step("pp3", 1, 0, 2);
    pp_step("pp4", 0, 1, 2);
    pp_step("pp5", 0, 1, 3);
    pp_step("pp6", 1, 0, 3);
    pp_step("pp7", 1, 0, 3);
    chk("pp_drop", 32'(pp_drop), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
